// File: rtl/hazard3_fetch_ahb_bridge.sv
// Fetch-port to AHB-Lite read-only bridge with a one-entry address-phase hold buffer.
// Optional macro HAZARD3_FETCH_ERR_CANCEL_EN: suppress address issue across a bus error response.
`default_nettype none

module hazard3_fetch_ahb_bridge #(
    parameter int W_ADDR = 32
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic [W_ADDR-1:0] mem_addr,
    input  logic              mem_size,
    input  logic              mem_priv,
    input  logic              mem_addr_vld,
    output logic              mem_addr_rdy,
    output logic [31:0]       mem_data,
    output logic              mem_data_err,
    output logic              mem_data_vld,

    output logic [W_ADDR-1:0] haddr,
    output logic [1:0]        htrans,
    output logic [2:0]        hsize,
    output logic [3:0]        hprot,
    output logic              hwrite,
    output logic              hmastlock,
    output logic [2:0]        hburst,
    input  logic              hready,
    input  logic              hresp,
    input  logic [31:0]       hrdata
);

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

    logic              aph_vld;
    logic [W_ADDR-1:0] aph_addr;
    logic              aph_size;
    logic              aph_priv;
    logic              dph_vld;

    logic              err_block;
    logic              accept;
    logic              issue;
    logic              aph_done;
    logic              sel_size;
    logic              sel_priv;

`ifdef HAZARD3_FETCH_ERR_CANCEL_EN
    // Block across both error cycles so nothing can complete on the second one.
    assign err_block = dph_vld && hresp;
`else
    assign err_block = 1'b0;
`endif

    assign mem_addr_rdy = !aph_vld && !err_block;
    assign accept       = mem_addr_vld && mem_addr_rdy;

    always_comb begin
        issue    = 1'b0;
        sel_size = mem_size;
        sel_priv = mem_priv;
        haddr    = mem_addr;
        if (aph_vld) begin
            issue    = 1'b1;
            sel_size = aph_size;
            sel_priv = aph_priv;
            haddr    = aph_addr;
        end else begin
            issue    = mem_addr_vld;
        end
    end

    assign htrans    = (issue && !err_block) ? HTRANS_NONSEQ : HTRANS_IDLE;
    assign hsize     = sel_size ? 3'd2 : 3'd1;
    assign hprot     = {2'b00, sel_priv, 1'b0};
    assign hwrite    = 1'b0;
    assign hmastlock = 1'b0;
    assign hburst    = 3'b000;

    assign aph_done  = hready && (htrans == HTRANS_NONSEQ);

    // Address-phase hold and data-phase tracking
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            aph_vld  <= 1'b0;
            aph_addr <= '0;
            aph_size <= 1'b0;
            aph_priv <= 1'b0;
            dph_vld  <= 1'b0;
        end else begin
            if (aph_done) begin
                aph_vld <= 1'b0;
                dph_vld <= 1'b1;
            end else begin
                if (accept) begin
                    aph_vld <= 1'b1;
                end
                if (hready) begin
                    dph_vld <= 1'b0;
                end
            end
            // The frontend may move on after acceptance, so a stalled request is frozen here.
            if (accept && !hready) begin
                aph_addr <= mem_addr;
                aph_size <= mem_size;
                aph_priv <= mem_priv;
            end
        end
    end

    // Response path is purely combinational from the data-phase handshake
    assign mem_data_vld = hready && dph_vld;
    assign mem_data_err = mem_data_vld && hresp;
    assign mem_data     = mem_data_vld ? hrdata : 32'h0;

endmodule

`default_nettype wire
